fifo_sync_param: RTL

Parametrised single-clock FIFO, successor to the team's fixed 8-bit/64-entry buffer. Generalises data width and depth; adds programmable almost-full/almost-empty thresholds, a first-word-fall-through (FWFT) read mode, defined simultaneous read/write behaviour at full and empty, and sticky overflow/underflow error flags. Used as the general-purpose elastic buffer between producer and consumer stages in the same clock domain.

---
 rtl/fifo_sync_param_if.sv | 33 +++
 rtl/fifo_sync_param.sv | 123 ++++++++++++
 2 files changed

// File: rtl/fifo_sync_param_if.sv
// Handshake/data bundle between a producer/consumer and fifo_sync_param.
// The producer/consumer side uses the master modport, the FIFO uses slave.
interface fifo_sync_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] buf_in;
  logic              rd_en;
  logic              err_clr;
  logic [DATA_W-1:0] buf_out;
  logic              buf_empty;
  logic              buf_full;
  logic              almost_empty;
  logic              almost_full;
  logic [CW-1:0]     fifo_counter;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, buf_in, rd_en, err_clr,
    input  buf_out, buf_empty, buf_full, almost_empty, almost_full,
           fifo_counter, overflow, underflow
  );

  modport slave (
    input  wr_en, buf_in, rd_en, err_clr,
    output buf_out, buf_empty, buf_full, almost_empty, almost_full,
           fifo_counter, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with programmable almost-full/almost-empty
// thresholds, optional first-word-fall-through output and sticky
// overflow/underflow flags. Every output comes straight from a register.
module fifo_sync_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0
) (
  input  logic                clk,
  input  logic                rst,
  fifo_sync_param_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage is deliberately not reset so it can map onto block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]     count_reg, count_next;
  logic              empty_reg, full_reg;
  logic              ae_reg, af_reg;
  logic              ovf_reg, udf_reg;
  logic [DATA_W-1:0] out_reg;

  logic              wa;   // write accepted this cycle
  logic              ra;   // read accepted this cycle

  // Accept/reject decisions, next pointers and next occupancy.
  // A write at full is only legal when a read frees the slot in the same
  // cycle; a read at empty is never legal, even alongside a write.
  always_comb begin
    wa          = bus.wr_en & (~full_reg | bus.rd_en);
    ra          = bus.rd_en & ~empty_reg;
    wr_ptr_next = wa ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
    rd_ptr_next = ra ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    case ({wa, ra})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers, occupancy and status flags. Flags are registered from the
  // next count so they always move on the same edge as fifo_counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      empty_reg  <= 1'b1;
      full_reg   <= 1'b0;
      ae_reg     <= 1'b1;
      af_reg     <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      empty_reg  <= (count_next == '0);
      full_reg   <= (count_next == CW'(DEPTH));
      ae_reg     <= (count_next <= CW'(AE_LEVEL));
      af_reg     <= (count_next >= CW'(AF_LEVEL));
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins over err_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_reg <= 1'b0;
      udf_reg <= 1'b0;
    end else begin
      ovf_reg <= (bus.wr_en & ~wa) | (ovf_reg & ~bus.err_clr);
      udf_reg <= (bus.rd_en & ~ra) | (udf_reg & ~bus.err_clr);
    end
  end

  // Storage write port; a write in a reset cycle is discarded.
  always_ff @(posedge clk) begin
    if (wa && !rst) begin
      mem[wr_ptr_reg] <= bus.buf_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // The new head is the word being written this cycle when it lands
      // exactly at the next read address (FIFO empty, or one word that is
      // popped while another is pushed); the array has not got it yet.
      logic bypass;
      assign bypass = wa && (wr_ptr_reg == rd_ptr_next);

      // Keep buf_out showing the head word; hold the last word once empty.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_reg <= '0;
        end else if (count_next != '0) begin
          out_reg <= bypass ? bus.buf_in : mem[rd_ptr_next];
        end
      end
    end else begin : g_std
      // Registered read: the popped word appears after the accepting edge.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_reg <= '0;
        end else if (ra) begin
          out_reg <= mem[rd_ptr_reg];
        end
      end
    end
  endgenerate

  assign bus.buf_out      = out_reg;
  assign bus.buf_empty    = empty_reg;
  assign bus.buf_full     = full_reg;
  assign bus.almost_empty = ae_reg;
  assign bus.almost_full  = af_reg;
  assign bus.fifo_counter = count_reg;
  assign bus.overflow     = ovf_reg;
  assign bus.underflow    = udf_reg;
endmodule
